nuc_axi_rd_arbiter: RTL

Shares one AXI4 read port among NUM_REQ frame-reader burst masters, such as the NUC gain/offset coefficient reader and the image frame reader. Arbitration is round-robin at burst granularity. Each granted burst's requester index is recorded in an in-order route FIFO, and R beats are steered back to that requester. The block sits between the reader burst masters and the DDR interconnect, in the `clk` domain.

---
 rtl/nuc_axi_rd_arbiter_pkg.sv | 25 ++
 rtl/nuc_route_fifo.sv | 77 +++++++
 rtl/nuc_axi_rd_arbiter.sv | 178 +++++++++++++++++
 3 files changed

// File: rtl/nuc_axi_rd_arbiter_pkg.sv
// Shared definitions for the NUC AXI read arbiter slice.
// Holds the fixed AR-channel attribute values, a constant-foldable clog2 and
// the requester-index width helper used by the top and the route FIFO.
package nuc_axi_rd_arbiter_pkg;

  // INCR bursts, normal non-cacheable bufferable.
  localparam logic [1:0] ArBurstIncr = 2'b01;
  localparam logic [3:0] ArCacheDefault = 4'b0011;
  localparam logic [2:0] ArProtDefault = 3'b000;

  // Ceiling log2; clog2(1) = 0.
  function automatic int unsigned clog2(input int unsigned value);
    int unsigned res = 0;
    for (int unsigned i = 0; i < 32; i++) begin
      if ((64'd1 << i) < 64'(value)) res = i + 1;
    end
    return res;
  endfunction

  // Requester index width; never narrower than one bit.
  function automatic int unsigned req_width(input int unsigned num_req);
    return (clog2(num_req) == 0) ? 1 : clog2(num_req);
  endfunction

endpackage

// File: rtl/nuc_route_fifo.sv
// In-order route FIFO: remembers which requester owns each granted burst.
// Ports:
//   clk, reset_n   clock, asynchronous active-low reset
//   push/push_data write one entry (ignored while full)
//   pop            drop the head entry (ignored while empty)
//   head           first-word-fall-through head entry
//   full, empty    registered status flags
//   count          current occupancy, 0..Depth
module nuc_route_fifo
  import nuc_axi_rd_arbiter_pkg::*;
#(
  parameter int unsigned Width = 1,
  parameter int unsigned Depth = 4
) (
  input  logic                    clk,
  input  logic                    reset_n,
  input  logic                    push,
  input  logic [Width-1:0]        push_data,
  input  logic                    pop,
  output logic [Width-1:0]        head,
  output logic                    full,
  output logic                    empty,
  output logic [clog2(Depth):0]   count
);

  localparam int unsigned PtrW = (clog2(Depth) == 0) ? 1 : clog2(Depth);
  localparam int unsigned CntW = clog2(Depth) + 1;

  logic [Width-1:0] mem_q [Depth];
  logic [PtrW-1:0]  wr_ptr_q, rd_ptr_q;
  logic [CntW-1:0]  count_q, count_d;
  logic             full_q, empty_q;
  logic             do_push, do_pop;

  function automatic logic [PtrW-1:0] ptr_next(input logic [PtrW-1:0] ptr);
    return (ptr == PtrW'(Depth - 1)) ? '0 : ptr + 1'b1;
  endfunction

  assign do_push = push & ~full_q;
  assign do_pop  = pop & ~empty_q;

  always_comb begin
    count_d = count_q;
    if (do_push && !do_pop) begin
      count_d = count_q + 1'b1;
    end else if (!do_push && do_pop) begin
      count_d = count_q - 1'b1;
    end
  end

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      wr_ptr_q <= '0;
      rd_ptr_q <= '0;
      count_q  <= '0;
      full_q   <= 1'b0;
      empty_q  <= 1'b1;
    end else begin
      if (do_push) wr_ptr_q <= ptr_next(wr_ptr_q);
      if (do_pop)  rd_ptr_q <= ptr_next(rd_ptr_q);
      count_q <= count_d;
      full_q  <= (count_d == CntW'(Depth));
      empty_q <= (count_d == '0);
    end
  end

  // Storage needs no reset: entries are only read behind the empty flag.
  always_ff @(posedge clk) begin
    if (do_push) mem_q[wr_ptr_q] <= push_data;
  end

  assign head  = mem_q[rd_ptr_q];
  assign full  = full_q;
  assign empty = empty_q;
  assign count = count_q;

endmodule

// File: rtl/nuc_axi_rd_arbiter.sv
// Round-robin AXI4 read-port arbiter for the NUC frame-reader masters.
// One burst is granted per cycle at most; the winner's index is queued in
// the route FIFO and R beats are steered back to the head-of-queue owner.
// Ports:
//   clk, reset_n            clock, asynchronous active-low reset
//   s_ar*                   per-requester AR (slice i = requester i), one-hot grant
//   s_r*                    R broadcast data, per-requester valid/ready
//   m_axi_ar*               registered AR towards the interconnect, constant attributes
//   m_axi_r*                R from the interconnect, combinational pass-through
//   outstanding             bursts granted and not yet closed by rlast
//   err_orphan_r            sticky: R beat seen with no burst outstanding
module nuc_axi_rd_arbiter
  import nuc_axi_rd_arbiter_pkg::*;
#(
  parameter int unsigned NUM_REQ         = 2,
  parameter int unsigned ADDRESSWIDTH    = 32,
  parameter int unsigned DATAWIDTH_MM    = 64,
  parameter int unsigned MAX_OUTSTANDING = 4
) (
  input  logic                              clk,
  input  logic                              reset_n,
  // Requester side
  input  logic [NUM_REQ*ADDRESSWIDTH-1:0]   s_araddr,
  input  logic [NUM_REQ*8-1:0]              s_arlen,
  input  logic [NUM_REQ-1:0]                s_arvalid,
  output logic [NUM_REQ-1:0]                s_arready,
  output logic [DATAWIDTH_MM-1:0]           s_rdata,
  output logic [1:0]                        s_rresp,
  output logic                              s_rlast,
  output logic [NUM_REQ-1:0]                s_rvalid,
  input  logic [NUM_REQ-1:0]                s_rready,
  // Interconnect side
  output logic [ADDRESSWIDTH-1:0]           m_axi_araddr,
  output logic [7:0]                        m_axi_arlen,
  output logic                              m_axi_arvalid,
  input  logic                              m_axi_arready,
  output logic [1:0]                        m_axi_arburst,
  output logic [2:0]                        m_axi_arsize,
  output logic [3:0]                        m_axi_arcache,
  output logic [2:0]                        m_axi_arprot,
  output logic [0:0]                        m_axi_aruser,
  input  logic [DATAWIDTH_MM-1:0]           m_axi_rdata,
  input  logic [1:0]                        m_axi_rresp,
  input  logic                              m_axi_rlast,
  input  logic                              m_axi_rvalid,
  output logic                              m_axi_rready,
  // Status
  output logic [clog2(MAX_OUTSTANDING):0]   outstanding,
  output logic                              err_orphan_r
);

  localparam int unsigned REQW   = req_width(NUM_REQ);
  localparam int unsigned ArSize = clog2(DATAWIDTH_MM / 8);

  logic [REQW-1:0]         last_grant_q;
  logic [REQW-1:0]         grant_idx;
  logic [REQW:0]           rr_sum;
  logic                    grant_found;
  logic                    ar_free;
  logic                    grant;

  logic [ADDRESSWIDTH-1:0] araddr_q;
  logic [7:0]              arlen_q;
  logic                    arvalid_q;
  logic                    err_orphan_q;

  logic [REQW-1:0]         route_head;
  logic                    route_full;
  logic                    route_empty;
  logic                    route_ne;
  logic                    route_pop;

  // ---------------------------------------------------------------------------
  // Round-robin arbitration
  // ---------------------------------------------------------------------------
  assign ar_free = ~arvalid_q | m_axi_arready;

  // Scan last_grant+1 .. last_grant+NUM_REQ (mod NUM_REQ); first requester wins.
  always_comb begin
    grant_idx   = last_grant_q;
    grant_found = 1'b0;
    rr_sum      = '0;
    for (int unsigned k = 1; k <= NUM_REQ; k++) begin
      rr_sum = {1'b0, last_grant_q} + (REQW + 1)'(k);
      if (rr_sum >= (REQW + 1)'(NUM_REQ)) rr_sum = rr_sum - (REQW + 1)'(NUM_REQ);
      if (!grant_found && s_arvalid[rr_sum[REQW-1:0]]) begin
        grant_found = 1'b1;
        grant_idx   = rr_sum[REQW-1:0];
      end
    end
  end

  // The registered full flag is used on purpose: a pop in the full cycle
  // frees a slot only from the next cycle. reset_n keeps the combinational
  // grant pulse quiet while reset is held.
  assign grant = reset_n & ar_free & ~route_full & grant_found;

  always_comb begin
    s_arready = '0;
    if (grant) s_arready = NUM_REQ'(1) << grant_idx;
  end

  // ---------------------------------------------------------------------------
  // AR register stage
  // ---------------------------------------------------------------------------
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      araddr_q     <= '0;
      arlen_q      <= '0;
      arvalid_q    <= 1'b0;
      last_grant_q <= REQW'(NUM_REQ - 1);
    end else if (grant) begin
      araddr_q     <= s_araddr[grant_idx*ADDRESSWIDTH +: ADDRESSWIDTH];
      arlen_q      <= s_arlen[grant_idx*8 +: 8];
      arvalid_q    <= 1'b1;
      last_grant_q <= grant_idx;
    end else if (m_axi_arready) begin
      arvalid_q    <= 1'b0;
    end
  end

  assign m_axi_araddr  = araddr_q;
  assign m_axi_arlen   = arlen_q;
  assign m_axi_arvalid = arvalid_q;
  assign m_axi_arburst = ArBurstIncr;
  assign m_axi_arsize  = 3'(ArSize);
  assign m_axi_arcache = ArCacheDefault;
  assign m_axi_arprot  = ArProtDefault;
  assign m_axi_aruser  = 1'b0;

  // ---------------------------------------------------------------------------
  // Route FIFO
  // ---------------------------------------------------------------------------
  nuc_route_fifo #(
    .Width (REQW),
    .Depth (MAX_OUTSTANDING)
  ) u_route_fifo (
    .clk       (clk),
    .reset_n   (reset_n),
    .push      (grant),
    .push_data (grant_idx),
    .pop       (route_pop),
    .head      (route_head),
    .full      (route_full),
    .empty     (route_empty),
    .count     (outstanding)
  );

  // ---------------------------------------------------------------------------
  // R steering (no data registers)
  // ---------------------------------------------------------------------------
  assign route_ne = ~route_empty;

  always_comb begin
    s_rvalid = '0;
    for (int unsigned i = 0; i < NUM_REQ; i++) begin
      s_rvalid[i] = m_axi_rvalid & route_ne & (route_head == REQW'(i));
    end
  end

  assign m_axi_rready = route_ne & s_rready[route_head];
  assign route_pop    = m_axi_rvalid & m_axi_rready & m_axi_rlast;

  assign s_rdata = m_axi_rdata;
  assign s_rresp = m_axi_rresp;
  assign s_rlast = m_axi_rlast;

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      err_orphan_q <= 1'b0;
    end else if (m_axi_rvalid && route_empty) begin
      err_orphan_q <= 1'b1;
    end
  end

  assign err_orphan_r = err_orphan_q;

endmodule
